// File: rtl/switch_event_conditioner.sv
// Switch event conditioner: synchronizes and debounces the raw slide
// switches and turns accepted level changes into press/release events.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-low reset
//   sw_raw        raw switch levels, asynchronous to clk
//   sw_clean      debounced switch levels
//   press_valid   one-cycle pulse, exactly one switch went 0->1
//   press_idx     index of the last single switch that went 0->1
//   release_valid one-cycle pulse, at least one switch went 1->0
//   multi_press   one-cycle pulse, two or more switches went 0->1 together
module switch_event_conditioner #(
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter int IDX_W           = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SW-1:0]  sw_raw,
    output logic [N_SW-1:0]  sw_clean,
    output logic             press_valid,
    output logic [IDX_W-1:0] press_idx,
    output logic             release_valid,
    output logic             multi_press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [N_SW-1:0]  sync1;
    logic [N_SW-1:0]  sync2;

    logic [CNT_W-1:0] cnt      [N_SW];
    logic [CNT_W-1:0] cnt_next [N_SW];

    logic [N_SW-1:0]  clean_next;
    logic [N_SW-1:0]  rise;
    logic [N_SW-1:0]  fall;

    logic             rise_any;
    logic             rise_many;
    logic [IDX_W-1:0] rise_idx;

    // Two-flop synchronizer; only sync2 is safe to use downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    // Per-bit debounce. A level is accepted only after it has differed
    // from sw_clean on DEBOUNCE_CYCLES consecutive edges; any return to
    // the old level restarts the qualification from zero.
    always_comb begin
        clean_next = sw_clean;
        for (int i = 0; i < N_SW; i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != sw_clean[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    clean_next[i] = sync2[i];
                end else begin
                    cnt_next[i] = cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Edges are taken against the value being accepted on this same
    // edge, so registered events line up with the new sw_clean.
    assign rise = clean_next & ~sw_clean;
    assign fall = ~clean_next & sw_clean;

    // Classify the rise vector as none / exactly one / several without
    // a full popcount: the second set bit seen flags rise_many.
    always_comb begin
        rise_any  = 1'b0;
        rise_many = 1'b0;
        rise_idx  = '0;
        for (int i = 0; i < N_SW; i++) begin
            if (rise[i]) begin
                if (rise_any) begin
                    rise_many = 1'b1;
                end
                rise_any = 1'b1;
                rise_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_SW; i++) begin
                cnt[i] <= '0;
            end
            sw_clean <= '0;
        end else begin
            for (int i = 0; i < N_SW; i++) begin
                cnt[i] <= cnt_next[i];
            end
            sw_clean <= clean_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            press_valid   <= 1'b0;
            press_idx     <= '0;
            release_valid <= 1'b0;
            multi_press   <= 1'b0;
        end else begin
            press_valid   <= rise_any & ~rise_many;
            multi_press   <= rise_many;
            release_valid <= |fall;
            // Index only tracks single presses; it holds otherwise.
            if (rise_any && !rise_many) begin
                press_idx <= rise_idx;
            end
        end
    end

endmodule

// File: doc/switch_event_conditioner.md
Name: switch_event_conditioner

Overview:
- Input stage that sits directly upstream of the password sequence checker.
- Takes the 10 raw slide switches (SW0..SW9) and passes each through a two-flop synchronizer and a per-switch debounce counter.
- Produces clean switch levels plus single-cycle "switch turned on" and "switch turned off" events with the switch index.
- The checker consumes these events, so it no longer samples raw, bouncing switch levels through its own slow clock.

Parameters:
- N_SW, 10: number of switches.
- DEBOUNCE_CYCLES, 250000: cycles a synchronized level must stay unchanged before it is accepted (5 ms at 50 MHz). Must be at least 2.
- CNT_W, 18: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- IDX_W, 4: width of the switch index. Must satisfy 2^IDX_W >= N_SW.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous active-low reset.
- sw_raw  in  N_SW  raw switch levels; asynchronous to clk.
- sw_clean  out  N_SW  debounced switch levels.
- press_valid  out  1  one-cycle pulse: exactly one switch went 0->1.
- press_idx  out  IDX_W  index of the last single switch that went 0->1.
- release_valid  out  1  one-cycle pulse: at least one switch went 1->0.
- multi_press  out  1  one-cycle pulse: two or more switches went 0->1 in the same cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - Synchronizer flops, sw_clean, all debounce counters and press_idx clear to 0.
  - press_valid, release_valid and multi_press clear to 0.
  - No event pulses are generated while rst=0.
- Synchronizer:
  - Per bit: sync1 <= sw_raw[i], then sync2 <= sync1.
  - Only sync2 is used downstream.
- Debounce, per bit i, evaluated on each clk edge:
  - If sync2[i] == sw_clean[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: sw_clean[i] <= sync2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - A glitch that returns to the old level before acceptance zeroes the counter. No output changes.
  - Bits are fully independent.
- Latency:
  - Count edge 1 as the first edge that samples the new sw_raw value.
  - If sw_raw holds that value, sw_clean[i] changes on edge DEBOUNCE_CYCLES+2.
- Edge detection:
  - rise = accepted-next & ~sw_clean.
  - fall = ~accepted-next & sw_clean.
  - Both are computed combinationally from the same-edge update.
  - Event outputs are registered, so they assert in the same cycle that sw_clean shows the new value.
- Press events:
  - popcount(rise)==1: press_valid=1 for one cycle and press_idx <= index of that bit.
  - popcount(rise)>=2: multi_press=1 for one cycle; press_valid stays 0 and press_idx is unchanged.
  - popcount(rise)==0: press_valid=0 and multi_press=0.
  - press_idx holds its value between events.
- Release events:
  - release_valid=1 for one cycle whenever fall != 0, regardless of the number of bits.
  - No index is given for releases.
- Simultaneous rise and fall in one cycle: both pulse types are reported in the same cycle, each by its own rule.
- Switch held high through reset: after rst deasserts, the switch is treated as a 0->1 change and produces a press event after the normal latency.
- Reset mid-debounce: counters are discarded. After reset the level is re-qualified from zero.
- Counters never wrap, because they clear at DEBOUNCE_CYCLES-1.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset, then set sw_raw=10'b0000000010 and hold -> on the 6th edge sw_clean=10'b0000000010, press_valid=1 for 1 cycle, press_idx=1.
2. Starting from step 1, set sw_raw=10'b0010000010, then 10'b0010000110, then 10'b0010000111, each held 10 cycles -> three press pulses with press_idx=7, 2, 0; release_valid never asserts.
3. Toggle sw_raw[5] 0->1->0 with the high level lasting 3 cycles, then hold it low -> sw_clean[5] stays 0 and no event pulses occur.
4. Set sw_raw=10'b0100100000 in a single cycle and hold -> multi_press=1 for one cycle, press_valid=0, press_idx unchanged, sw_clean=10'b0100100000.
5. Starting from sw_clean=10'b0010000111, set sw_raw=0 -> on the 6th edge sw_clean=0, release_valid=1 for one cycle, press_valid=0.
6. Hold sw_raw[1]=1, pulse rst low for 3 cycles at debounce count 2, then release -> all outputs are 0 during reset, and press_valid with press_idx=1 arrives on the 6th edge after rst rises.
